regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the single register-file write port among NREQ write-back requesters (ALU, load unit, multiply/divide unit) in the multi-cycle/pipelined MIPS core. Each cycle it grants at most one valid request and registers the winning address and data. It drives the write port one cycle later, including a 32-bit one-hot write-enable vector for the register file's per-register enables. Writes to $0 are accepted and consumed but never asserted on the port.

## Interface
Parameters:
- NREQ, 3, number of write-back requesters (2..8)
- IDW, $clog2(NREQ), width of grant index

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester grant; a transfer occurs when valid&ready
- req_waddr  in  NREQ*5  destination register, requester i at [5i+4:5i]
- req_wdata  in  NREQ*32  write data, requester i at [32i+31:32i]
- hold  in  1  freeze arbitration; forces all req_ready low
- rf_we  out  1  write strobe to register file
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- rf_wen_onehot  out  32  decoded write enable; bit k set iff rf_we and rf_waddr==k
- grant_id  out  IDW  index of the requester that produced the current rf_* write

## Operation
- Arbitration is combinational on req_valid, hold and the priority pointer `last`, which is registered and IDW bits wide.
- With hold=1 or no valid request, req_ready = 0.
- Otherwise exactly one req_ready bit is set: the first valid index searched from last+1 upward, wrapping from NREQ-1 to 0.
- req_ready[i] never asserts without req_valid[i].
- On a transfer the block latches the address, data and index, and updates `last` to the granted index.
- The output stage is a register stage only. rf_we = 1 in the cycle after a transfer with waddr != 0. Otherwise rf_we = 0.
- A transfer with waddr == 0 is consumed: ready is asserted and `last` advances. rf_we, rf_wen_onehot and rf_waddr stay 0 the next cycle.
- rf_wen_onehot is decoded from the registered address and gated by rf_we.
- Requesters hold valid, waddr and wdata stable until ready. Withdrawing valid before a grant is legal; the block ignores the withdrawn request.
- Widths: waddr is 5 bits, data is 32 bits, and neither is modified. `last` wrap uses compare-to-NREQ-1, not modulo arithmetic.

## Timing
- Reset (resetn=0, asynchronous) forces:
  - rf_we=0, rf_waddr=0, rf_wdata=0, rf_wen_onehot=0, grant_id=0
  - last = NREQ-1, so requester 0 has highest priority on the first grant
- req_ready is combinational from inputs and state, with zero latency.
- Write latency is 1 cycle: transfer at edge N gives rf_* valid during cycle N+1.
- Throughput is one write per cycle. Back-to-back grants to different requesters are allowed.
- A single requester with continuous valid is granted every cycle when the others are idle.
- hold rising in cycle N: no transfer in N, and rf_we=0 in N+1. A write already latched at edge N-1 still appears in N.
- resetn asserted mid-operation drops any latched write; it never reaches the register file.
- Simultaneous requests to the same waddr from two requesters: only one is granted per cycle. Order follows round-robin, and the last granted write wins.

## Configuration
- REGFILE_WB_ARB_RR_EN defined: round-robin as described above.
- REGFILE_WB_ARB_RR_EN undefined: fixed priority, where the lowest valid index wins. `last` is not implemented and grant_id still reports the winner.
- All other behaviour and timing are identical in both configurations.

## Structure
- Shared package holds:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_NUM=32
  - REG_ZERO=5'd0
- Sub-module: decoder_5_32, instantiated on rf_waddr, output ANDed with rf_we to form rf_wen_onehot.
- The arbiter's next-grant search is a generate loop in the top module. No further sub-modules.

## Test plan
- Reset: hold resetn=0 with all req_valid=3'b111 → req_ready=0, rf_we=0, rf_wen_onehot=0. Release → first grant goes to requester 0.
- Round-robin, RR_EN defined: req_valid=3'b111 held for 6 cycles → grants 0,1,2,0,1,2. Waddrs 8,9,10 give rf_wen_onehot 0x100, 0x200, 0x400 one cycle after each grant.
- $0 write: requester 1 sends waddr=0, wdata=0xDEADBEEF → req_ready[1]=1, next cycle rf_we=0 and rf_wen_onehot=0. The pointer advances, so requester 2 wins the next contended cycle.
- hold: valid=3'b011 with hold=1 for 3 cycles → req_ready=0 and rf_we=0. Drop hold → requester 0 granted, rf_wdata matches one cycle later.
- Fixed priority, RR_EN undefined: req_valid=3'b110 for 3 cycles → requester 1 granted every cycle and requester 2 starved.
- Reset mid-write: transfer of waddr=5 at edge N, resetn low during cycle N+1 → rf_we=0 immediately and no write to r5.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//   Shared register-file constants for the write-back arbiter and its decoder.
//
//   REG_ADDR_W : register address width (5)
//   REG_DATA_W : register data width (32)
//   REG_NUM    : number of architectural registers (32)
//   REG_ZERO   : address of the hard-wired zero register
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_NUM    = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : regfile_wb_arbiter_pkg

// File: rtl/regfile_wb_arbiter_decoder_5_32.sv
// -----------------------------------------------------------------------------
// decoder_5_32
//   Binary-to-one-hot decoder for the register-file write enables.
//
//   addr   in  REG_ADDR_W  register address
//   onehot out REG_NUM     bit k set iff addr == k
// -----------------------------------------------------------------------------
module decoder_5_32
    import regfile_wb_arbiter_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    output logic [REG_NUM-1:0]    onehot
);

    assign onehot = REG_NUM'(1) << addr;

endmodule : decoder_5_32

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port among NREQ write-back
//   requesters. At most one valid request is granted per cycle; the winner's
//   address, data and index are registered and drive the write port in the
//   following cycle. Writes to $0 are granted and consumed but never strobed.
//
//   Build option:
//     REG FILE_WB_ARB_RR_EN  -> see macro REGFILE_WB_ARB_RR_EN
//     REGFILE_WB_ARB_RR_EN defined   : round-robin from the last granted index
//     REGFILE_WB_ARB_RR_EN undefined : fixed priority, lowest valid index wins
//
//   Ports:
//     clk           in   1        clock, rising edge
//     resetn        in   1        asynchronous active-low reset
//     req_valid     in   NREQ     per-requester write request
//     req_ready     out  NREQ     per-requester grant (transfer = valid&ready)
//     req_waddr     in   NREQ*5   destination register, requester i at [5i+:5]
//     req_wdata     in   NREQ*32  write data, requester i at [32i+:32]
//     hold          in   1        freeze arbitration, forces req_ready low
//     rf_we         out  1        register-file write strobe
//     rf_waddr      out  5        write address
//     rf_wdata      out  32       write data
//     rf_wen_onehot out  32       per-register write enables, gated by rf_we
//     grant_id      out  IDW      requester that produced the current write
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*REG_ADDR_W-1:0] req_waddr,
    input  logic [NREQ*REG_DATA_W-1:0] req_wdata,
    input  logic                       hold,
    output logic                       rf_we,
    output logic [REG_ADDR_W-1:0]      rf_waddr,
    output logic [REG_DATA_W-1:0]      rf_wdata,
    output logic [REG_NUM-1:0]         rf_wen_onehot,
    output logic [IDW-1:0]             grant_id
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    // Search order: position k of the scan holds the requester index examined
    // k-th. The first valid position wins.
    logic [NREQ*IDW-1:0] cand_flat;
    logic [NREQ-1:0]     cand_valid;

`ifdef REGFILE_WB_ARB_RR_EN
    logic [IDW-1:0] last;
`endif

    genvar k;
    generate
        for (k = 0; k < NREQ; k++) begin : g_search
            logic [IDW-1:0] idx;
`ifdef REGFILE_WB_ARB_RR_EN
            // Walk upward from last+1, wrapping NREQ-1 -> 0 by compare.
            if (k == 0) begin : g_first
                assign idx = (last == LAST_IDX) ? '0 : last + IDW'(1);
            end else begin : g_next
                assign idx = (g_search[k-1].idx == LAST_IDX) ? '0
                           : g_search[k-1].idx + IDW'(1);
            end
`else
            assign idx = IDW'(k);
`endif
            assign cand_flat[k*IDW +: IDW] = idx;
            assign cand_valid[k]           = req_valid[idx];
        end
    endgenerate

    logic                  gnt_any;
    logic [IDW-1:0]        gnt_idx;
    logic [REG_ADDR_W-1:0] gnt_waddr;
    logic [REG_DATA_W-1:0] gnt_wdata;

    // NOTE: every output of this block gets a default first, so no path
    // through it can leave a signal unassigned and infer a latch.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        // Descending scan so the lowest search position is assigned last.
        for (int p = NREQ - 1; p >= 0; p--) begin
            if (cand_valid[p]) begin
                gnt_idx = cand_flat[p*IDW +: IDW];
            end
        end
        // No grants while in reset so nothing is handshaken away unseen.
        if (resetn && !hold && (|cand_valid)) begin
            gnt_any            = 1'b1;
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign gnt_waddr = req_waddr[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign gnt_wdata = req_wdata[int'(gnt_idx)*REG_DATA_W +: REG_DATA_W];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            grant_id <= '0;
        end else if (gnt_any) begin
            // A $0 write is consumed here: latched, but never strobed.
            rf_we    <= (gnt_waddr != REG_ZERO);
            rf_waddr <= gnt_waddr;
            rf_wdata <= gnt_wdata;
            grant_id <= gnt_idx;
        end else begin
            rf_we    <= 1'b0;
        end
    end

`ifdef REGFILE_WB_ARB_RR_EN
    // Reset to NREQ-1 so requester 0 is first in line after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last <= LAST_IDX;
        end else if (gnt_any) begin
            last <= gnt_idx;
        end
    end
`endif

    logic [REG_NUM-1:0] dec_onehot;

    decoder_5_32 u_dec (
        .addr   (rf_waddr),
        .onehot (dec_onehot)
    );

    assign rf_wen_onehot = dec_onehot & {REG_NUM{rf_we}};

endmodule : regfile_wb_arbiter
